// File: rtl/i2s_playback_tx.sv
// I2S playback serializer: stereo PCM frames from a valid/ready stream are
// buffered in a small FIFO and shifted MSB-first onto sdata, timed by bclk/lrclk.
module i2s_playback_tx #(
   parameter int SAMPLE_W   = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          enable,
   input  logic [2*SAMPLE_W-1:0]         s_data,
   input  logic                          s_valid,
   output logic                          s_ready,
   input  logic                          bclk,
   input  logic                          playback_lrclk,
   output logic                          sdata,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          underrun,
   output logic [15:0]                   underrun_count
);

   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int LVL_W   = PTR_W + 1;
   localparam int CNT_W   = $clog2(SAMPLE_W);
   localparam int FRAME_W = 2 * SAMPLE_W;

   logic                bclk_s1_q, bclk_s1_d, bclk_s2_q, bclk_s2_d, bclk_s3_q, bclk_s3_d;
   logic                lr_s1_q, lr_s1_d, lr_s2_q, lr_s2_d;
   logic                rise_q, rise_d, fall_q, fall_d;
   logic                armed_q, armed_d;
   logic                lr_cur_q, lr_cur_d, lr_prev_q, lr_prev_d;
   logic [SAMPLE_W-1:0] shift_q, shift_d;
   logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
   logic                sdata_q, sdata_d;
   logic [FRAME_W-1:0]  frame_q, frame_d;
   logic                underrun_q, underrun_d;
   logic [15:0]         ucount_q, ucount_d;
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]    level_q, level_d;
   logic                s_ready_q, s_ready_d;
   logic [FRAME_W-1:0]  mem_q [FIFO_DEPTH];

   logic                push, pop, load, fifo_empty;
   logic [FRAME_W-1:0]  head;
   logic [SAMPLE_W-1:0] load_word;

   assign fifo_empty = (level_q == '0);
   assign head       = mem_q[rd_ptr_q];
   assign push       = enable & s_valid & s_ready_q;
   // A word loads only on the first falling edge after a recognized lrclk change.
   assign load       = enable & fall_q & armed_q & (lr_cur_q != lr_prev_q);
   assign pop        = load & ~lr_cur_q & ~fifo_empty;

   always_comb begin
      bclk_s1_d   = bclk;
      bclk_s2_d   = bclk_s1_q;
      bclk_s3_d   = bclk_s2_q;
      lr_s1_d     = playback_lrclk;
      lr_s2_d     = lr_s1_q;
      rise_d      = bclk_s2_q & ~bclk_s3_q;
      fall_d      = ~bclk_s2_q & bclk_s3_q;

      armed_d     = armed_q;
      lr_cur_d    = lr_cur_q;
      lr_prev_d   = lr_prev_q;
      if (rise_q) begin
         lr_cur_d = lr_s2_q;
         if (enable && !armed_q) begin
            armed_d   = 1'b1;
            lr_prev_d = lr_s2_q;
         end else begin
            lr_prev_d = lr_cur_q;
         end
      end
      if (!enable) armed_d = 1'b0;
   end

   always_comb begin
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
      sdata_d    = sdata_q;
      frame_d    = frame_q;
      underrun_d = 1'b0;
      ucount_d   = ucount_q;
      load_word  = '0;

      if (load) begin
         if (!lr_cur_q) begin
            if (!fifo_empty) begin
               frame_d   = head;
               load_word = head[FRAME_W-1:SAMPLE_W];
            end else begin
               frame_d    = '0;
               underrun_d = 1'b1;
               if (ucount_q != '1) ucount_d = ucount_q + 16'd1;
            end
         end else begin
            load_word = frame_q[SAMPLE_W-1:0];
         end
         sdata_d   = load_word[SAMPLE_W-1];
         shift_d   = {load_word[SAMPLE_W-2:0], 1'b0};
         bit_cnt_d = CNT_W'(SAMPLE_W - 1);
      end else if (fall_q) begin
         if (bit_cnt_q != '0) begin
            sdata_d   = shift_q[SAMPLE_W-1];
            shift_d   = {shift_q[SAMPLE_W-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q - 1'b1;
         end else begin
            sdata_d   = 1'b0;
         end
      end

      if (!enable) begin
         sdata_d   = 1'b0;
         shift_d   = '0;
         bit_cnt_d = '0;
      end
   end

   always_comb begin
      wr_ptr_d  = wr_ptr_q + PTR_W'(push);
      rd_ptr_d  = rd_ptr_q + PTR_W'(pop);
      level_d   = level_q + LVL_W'(push) - LVL_W'(pop);
      if (!enable) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end
      s_ready_d = enable && (level_d < LVL_W'(FIFO_DEPTH));
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= s_data;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bclk_s1_q  <= 1'b0;
         bclk_s2_q  <= 1'b0;
         bclk_s3_q  <= 1'b0;
         lr_s1_q    <= 1'b0;
         lr_s2_q    <= 1'b0;
         rise_q     <= 1'b0;
         fall_q     <= 1'b0;
         armed_q    <= 1'b0;
         lr_cur_q   <= 1'b0;
         lr_prev_q  <= 1'b0;
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         sdata_q    <= 1'b0;
         frame_q    <= '0;
         underrun_q <= 1'b0;
         ucount_q   <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         s_ready_q  <= 1'b0;
      end else begin
         bclk_s1_q  <= bclk_s1_d;
         bclk_s2_q  <= bclk_s2_d;
         bclk_s3_q  <= bclk_s3_d;
         lr_s1_q    <= lr_s1_d;
         lr_s2_q    <= lr_s2_d;
         rise_q     <= rise_d;
         fall_q     <= fall_d;
         armed_q    <= armed_d;
         lr_cur_q   <= lr_cur_d;
         lr_prev_q  <= lr_prev_d;
         shift_q    <= shift_d;
         bit_cnt_q  <= bit_cnt_d;
         sdata_q    <= sdata_d;
         frame_q    <= frame_d;
         underrun_q <= underrun_d;
         ucount_q   <= ucount_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         s_ready_q  <= s_ready_d;
      end
   end

   assign s_ready        = s_ready_q;
   assign sdata          = sdata_q;
   assign fifo_level     = level_q;
   assign underrun       = underrun_q;
   assign underrun_count = ucount_q;

endmodule

// File: tb/tb_i2s_playback_tx.sv
// Bench for i2s_playback_tx: drives bclk/lrclk slots, random frames, and compares
// every bit slot against an I2S frame model (bit j of a word follows lrclk by j+1 bclks).
module tb_i2s_playback_tx;

   localparam int SW    = 16;
   localparam int DEPTH = 4;
   localparam int H     = 6;

   logic        clk = 1'b0;
   logic        reset_n, enable, s_valid, bclk, lrclk;
   logic [31:0] s_data;
   logic        s_ready, sdata, underrun;
   logic [2:0]  fifo_level;
   logic [15:0] underrun_count;

   always #5 clk = ~clk;

   i2s_playback_tx #(.SAMPLE_W(SW), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .reset_n(reset_n), .enable(enable),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .bclk(bclk), .playback_lrclk(lrclk), .sdata(sdata),
      .fifo_level(fifo_level), .underrun(underrun), .underrun_count(underrun_count)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // model state
   logic [31:0] m_q[$];
   bit          m_armed  = 0;
   bit          m_active = 0;
   int          m_len    = 0;
   logic [31:0] m_frame  = '0;
   logic [15:0] m_word   = '0;
   int          m_under  = 0;
   int          pulses   = 0;
   int          pulse_base = 0;

   always @(negedge clk) if (underrun === 1'b1) pulses++;

   initial begin
      #10_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Runs bclk falls k0..k1-1 of one slot; caller sits on a clk negedge.
   task automatic run_slot(input int ch, input int len, input int k0, input int k1);
      logic e;
      for (int k = k0; k < k1; k++) begin
         bclk = 1'b0;
         e = 1'b0;
         if (k == 0) begin
            e = (m_active && m_len == SW) ? m_word[0] : 1'b0;
            lrclk    = ch[0];
            m_active = m_armed;
            m_len    = len;
            if (!m_active) m_word = '0;
         end else begin
            if (k == 1 && m_active) begin
               if (ch == 0) begin
                  if (m_q.size() > 0) m_frame = m_q.pop_front();
                  else begin
                     m_frame = '0;
                     m_under++;
                  end
                  m_word = m_frame[31:16];
               end else begin
                  m_word = m_frame[15:0];
               end
            end
            if (m_active && k <= SW) e = m_word[SW-k];
         end
         repeat (H) @(negedge clk);
         chk("sdata", {63'd0, sdata}, {63'd0, e});
         bclk = 1'b1;
         if (enable) m_armed = 1;
         repeat (H) @(negedge clk);
      end
   endtask

   task automatic run_frame(input int len);
      run_slot(0, len, 0, len);
      run_slot(1, len, 0, len);
   endtask

   task automatic push_cyc(input logic [31:0] d);
      bit acc;
      s_data  = d;
      s_valid = 1'b1;
      acc = enable && (m_q.size() < DEPTH);
      chk("s_ready", {63'd0, s_ready}, {63'd0, acc});
      @(negedge clk);
      if (acc) m_q.push_back(d);
   endtask

   task automatic chk_status();
      chk("fifo_level", {61'd0, fifo_level}, 64'(m_q.size()));
      chk("underrun_count", {48'd0, underrun_count}, 64'(m_under));
      chk("underrun_pulses", 64'(pulses - pulse_base), 64'(m_under));
   endtask

   initial begin
      logic [31:0] fifth;
      int n, len;
      reset_n = 1'b0; enable = 1'b0; s_valid = 1'b0; s_data = '0;
      bclk = 1'b1; lrclk = 1'b1;
      repeat (4) @(negedge clk);
      chk("rst_sdata", {63'd0, sdata}, 64'd0);
      chk("rst_s_ready", {63'd0, s_ready}, 64'd0);
      chk("rst_level", {61'd0, fifo_level}, 64'd0);
      chk("rst_underrun", {63'd0, underrun}, 64'd0);
      chk("rst_ucount", {48'd0, underrun_count}, 64'd0);
      reset_n = 1'b1;
      repeat (4) @(negedge clk);

      // enable raised mid right slot; first word must be the left half of the head
      run_slot(1, 16, 0, 6);
      chk("s_ready_disabled", {63'd0, s_ready}, 64'd0);
      enable = 1'b1;
      repeat (2) @(negedge clk);
      push_cyc(32'hA5F0_0F5A);
      s_valid = 1'b0;
      chk_status();
      run_slot(1, 16, 6, 16);
      run_frame(16);
      chk_status();

      // three frames with nothing queued
      repeat (3) run_frame(16);
      chk_status();

      // fill FIFO with bclk idle, fifth refused until a frame is transmitted
      for (int i = 0; i < 4; i++) push_cyc($urandom);
      fifth = $urandom;
      push_cyc(fifth);
      s_valid = 1'b0;
      chk("full_level", {61'd0, fifo_level}, 64'd4);
      run_frame(32);
      chk_status();
      push_cyc(fifth);
      s_valid = 1'b0;
      chk("refill_level", {61'd0, fifo_level}, 64'd4);

      // random bursts and slot lengths
      for (int it = 0; it < 10; it++) begin
         n = $urandom_range(0, 4);
         for (int i = 0; i < n; i++) push_cyc($urandom);
         s_valid = 1'b0;
         chk_status();
         len = 16 + 8 * $urandom_range(0, 2);
         run_frame(len);
         chk_status();
      end

      // asynchronous reset in the middle of a left word
      run_slot(0, 16, 0, 6);
      reset_n = 1'b0;
      #1;
      chk("midrst_sdata", {63'd0, sdata}, 64'd0);
      chk("midrst_s_ready", {63'd0, s_ready}, 64'd0);
      chk("midrst_level", {61'd0, fifo_level}, 64'd0);
      chk("midrst_underrun", {63'd0, underrun}, 64'd0);
      chk("midrst_ucount", {48'd0, underrun_count}, 64'd0);
      m_q.delete();
      m_armed = 0; m_active = 0; m_word = '0; m_frame = '0; m_under = 0;
      @(negedge clk);
      pulse_base = pulses;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      push_cyc($urandom);
      s_valid = 1'b0;
      run_slot(1, 16, 0, 16);
      run_frame(16);
      chk_status();
      run_frame(16);
      chk_status();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
